// File: rtl/seg_text_ctrl.sv
// rtl/seg_text_ctrl.sv - ASCII-to-glyph 8-digit shift buffer with backspace, clear and newest-digit blink
// Optional feature macro: SEG_DP_MARK_EN ('.' marks the decimal point of digit 0 instead of shifting)
module seg_text_ctrl #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  input  logic        clr,
  input  logic        blink_en,
  output logic [63:0] seg_val,
  output logic [3:0]  char_cnt
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ENCODE, SHIFT} state_t;

  state_t      state, state_nx;
  logic [7:0]  ch_reg;
  logic [7:0]  glyph;
  logic        bs_flag;
  logic [63:0] digits, digits_nx;
  logic [3:0]  cnt_nx;
  logic        shift_done;
  logic [CW-1:0] blink_cnt, blink_cnt_nx;
  logic        phase, phase_nx;
`ifdef SEG_DP_MARK_EN
  logic        dp_flag;
`endif

  function automatic logic [7:0] encode(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      8'h30: encode = 8'h3F;  8'h31: encode = 8'h06;  8'h32: encode = 8'h5B;
      8'h33: encode = 8'h4F;  8'h34: encode = 8'h66;  8'h35: encode = 8'h6D;
      8'h36: encode = 8'h7D;  8'h37: encode = 8'h07;  8'h38: encode = 8'h7F;
      8'h39: encode = 8'h6F;
      8'h41: encode = 8'h77;  8'h42: encode = 8'h7C;  8'h43: encode = 8'h39;
      8'h44: encode = 8'h5E;  8'h45: encode = 8'h79;  8'h46: encode = 8'h71;
      8'h47: encode = 8'h3D;  8'h48: encode = 8'h76;  8'h49: encode = 8'h30;
      8'h4A: encode = 8'h1E;  8'h4B: encode = 8'h75;  8'h4C: encode = 8'h38;
      8'h4D: encode = 8'h37;  8'h4E: encode = 8'h54;  8'h4F: encode = 8'h5C;
      8'h50: encode = 8'h73;  8'h51: encode = 8'h67;  8'h52: encode = 8'h50;
      8'h53: encode = 8'h6D;  8'h54: encode = 8'h78;  8'h55: encode = 8'h3E;
      8'h56: encode = 8'h1C;  8'h57: encode = 8'h2A;  8'h58: encode = 8'h64;
      8'h59: encode = 8'h6E;  8'h5A: encode = 8'h5B;
      8'h20: encode = 8'h00;  8'h2D: encode = 8'h40;  8'h2E: encode = 8'h80;
      default: encode = 8'h40;
    endcase
  endfunction

  assign ch_ready = (state == IDLE) & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ch_valid && ch_ready) state_nx = ENCODE;
      ENCODE:  state_nx = SHIFT;
      SHIFT:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (clr) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_reg  <= 8'h00;
      glyph   <= 8'h00;
      bs_flag <= 1'b0;
    end else begin
      if (state == IDLE && ch_valid && ch_ready) ch_reg <= ch_data;
      if (state == ENCODE) begin
        glyph   <= encode(ch_reg);
        bs_flag <= (ch_reg == 8'h08);
      end
    end
  end

`ifdef SEG_DP_MARK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  dp_flag <= 1'b0;
    else if (state == ENCODE) dp_flag <= (ch_reg == 8'h2E);
  end
`endif

  // Buffer update; clear wins over any in-flight SHIFT
  always_comb begin
    digits_nx  = digits;
    cnt_nx     = char_cnt;
    shift_done = 1'b0;
    if (clr) begin
      digits_nx = 64'h0;
      cnt_nx    = 4'd0;
    end else if (state == SHIFT) begin
      shift_done = 1'b1;
      if (bs_flag) begin
        if (char_cnt != 4'd0) begin
          digits_nx = {8'h00, digits[63:8]};
          cnt_nx    = char_cnt - 4'd1;
        end
`ifdef SEG_DP_MARK_EN
      end else if (dp_flag && char_cnt != 4'd0) begin
        digits_nx[7:0] = digits[7:0] | 8'h80;
`endif
      end else begin
        digits_nx = {digits[55:0], glyph};
        cnt_nx    = (char_cnt == 4'd8) ? 4'd8 : char_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    blink_cnt_nx = blink_cnt;
    phase_nx     = phase;
    if (!blink_en || shift_done) begin
      blink_cnt_nx = '0;
      phase_nx     = 1'b1;
    end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
      blink_cnt_nx = '0;
      phase_nx     = ~phase;
    end else begin
      blink_cnt_nx = blink_cnt + 1'b1;
    end
  end

  // seg_val is built from next-state values so it is a clean register output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits    <= 64'h0;
      char_cnt  <= 4'd0;
      blink_cnt <= '0;
      phase     <= 1'b1;
      seg_val   <= 64'h0;
    end else begin
      digits    <= digits_nx;
      char_cnt  <= cnt_nx;
      blink_cnt <= blink_cnt_nx;
      phase     <= phase_nx;
      seg_val   <= {digits_nx[63:8], phase_nx ? digits_nx[7:0] : 8'h00};
    end
  end

endmodule

// File: tb/tb_seg_text_ctrl.sv
// tb/tb_seg_text_ctrl.sv - directed and random checks of seg_text_ctrl against a glyph-list model
module tb_seg_text_ctrl;

  localparam int BD = 4;

  logic        clk = 1'b0;
  logic        rst, ch_valid, clr, blink_en;
  logic [7:0]  ch_data;
  logic        ch_ready;
  logic [63:0] seg_val;
  logic [3:0]  char_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] m [8];
  int         mcnt;

  logic [7:0] dg [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  logic [7:0] lg [26] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30,
                          8'h1E, 8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73, 8'h67, 8'h50,
                          8'h6D, 8'h78, 8'h3E, 8'h1C, 8'h2A, 8'h64, 8'h6E, 8'h5B};

  seg_text_ctrl #(.BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data), .ch_ready(ch_ready),
    .clr(clr), .blink_en(blink_en), .seg_val(seg_val), .char_cnt(char_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] glyph_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
    if (u >= "0" && u <= "9") return dg[u - "0"];
    if (u >= "A" && u <= "Z") return lg[u - "A"];
    if (u == " ") return 8'h00;
    if (u == "-") return 8'h40;
    if (u == ".") return 8'h80;
    return 8'h40;
  endfunction

  function automatic logic [63:0] model_seg();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = m[k];
    return v;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 8; k++) m[k] = 8'h00;
    mcnt = 0;
  endtask

  task automatic model_apply(input logic [7:0] c);
    if (c == 8'h08) begin
      if (mcnt > 0) begin
        for (int k = 0; k < 7; k++) m[k] = m[k+1];
        m[7] = 8'h00;
        mcnt--;
      end
      return;
    end
`ifdef SEG_DP_MARK_EN
    if (c == "." && mcnt > 0) begin
      m[0] = m[0] | 8'h80;
      return;
    end
`endif
    for (int k = 7; k > 0; k--) m[k] = m[k-1];
    m[0] = glyph_of(c);
    if (mcnt < 8) mcnt++;
  endtask

  task automatic send(input logic [7:0] c);
    int guard;
    logic [63:0] old;
    guard = 0;
    @(negedge clk);
    while (!ch_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", ch_ready, 1);
    old = model_seg();
    ch_valid = 1'b1;
    ch_data  = c;
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    check("busy_encode", ch_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("busy_shift", ch_ready, 0);
    check("hold_seg", seg_val, old);
    model_apply(c);
    @(posedge clk);
    @(negedge clk);
    check("ready_back", ch_ready, 1);
    check("seg", seg_val, model_seg());
    check("cnt", char_cnt, 64'(mcnt));
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("clr_seg", seg_val, 0);
    check("clr_cnt", char_cnt, 0);
  endtask

  initial begin
    string s;
    logic [7:0] c;
    rst = 1'b1; ch_valid = 1'b0; ch_data = 8'h00; clr = 1'b0; blink_en = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_seg", seg_val, 0);
    check("reset_cnt", char_cnt, 0);

    // reset while a character is in SHIFT
    @(negedge clk);
    ch_valid = 1'b1; ch_data = "3";
    @(posedge clk);
    @(negedge clk);
    ch_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_seg", seg_val, 0);
    check("rst_mid_cnt", char_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_rel_ready", ch_ready, 1);
    @(negedge clk);
    check("rst_rel_seg", seg_val, 0);
    check("rst_rel_cnt", char_cnt, 0);

    // '1' then '2' with ch_valid held
    ch_valid = 1'b1; ch_data = "1";
    @(posedge clk); @(negedge clk);
    ch_data = "2";
    check("held_r1", ch_ready, 0);
    @(posedge clk); @(negedge clk);
    check("held_r2", ch_ready, 0);
    @(posedge clk); @(negedge clk);
    check("held_r3", ch_ready, 1);
    check("held_seg1", seg_val, 64'h06);
    @(posedge clk); @(negedge clk);
    ch_valid = 1'b0;
    check("held_r4", ch_ready, 0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("held_seg2", seg_val[15:0], 16'h065B);
    check("held_cnt", char_cnt, 2);
    model_apply("1"); model_apply("2");

    // overflow: 'A' falls off the end
    do_clr();
    s = "ABCDEFGH0";
    for (int i = 0; i < s.len(); i++) send(s[i]);
    check("ovf_seg", seg_val, 64'h7C39_5E79_713D_763F);
    check("ovf_cnt", char_cnt, 8);

    // backspace down to empty and beyond
    do_clr();
    send("1"); send("2"); send(8'h08);
    check("bs_seg", seg_val[15:0], 16'h0006);
    check("bs_cnt", char_cnt, 1);
    repeat (3) send(8'h08);
    check("bs_empty_seg", seg_val, 0);
    check("bs_empty_cnt", char_cnt, 0);

    // clear right after accepting '7'
    send("5");
    @(negedge clk);
    ch_valid = 1'b1; ch_data = "7";
    @(posedge clk); @(negedge clk);
    ch_valid = 1'b0; clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    model_clear();
    check("clr7_seg", seg_val, 0);
    check("clr7_cnt", char_cnt, 0);
    @(posedge clk); @(negedge clk);
    check("clr7_seg2", seg_val, 0);
    check("clr7_ready", ch_ready, 1);

    // blink on the newest digit
    send("8");
    blink_en = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      @(posedge clk); @(negedge clk);
      check("blink", seg_val[7:0], ((j / BD) % 2 == 0) ? 8'h7F : 8'h00);
    end
    blink_en = 1'b0;
    @(posedge clk); @(negedge clk);
    check("blink_off", seg_val, model_seg());
    send(".");
    check("dot_d0", seg_val[7:0], m[0]);

    // random traffic
    do_clr();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0:       c = 8'h08;
        1:       c = 8'($urandom_range(0, 255));
        default: c = 8'($urandom_range(32, 126));
      endcase
      send(c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
